// File: rtl/io_fabric_pkg.sv
// Shared types and helpers for the IO-bus fabric.
package io_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    MISS_RESP = 2'd2
  } io_fabric_state_t;

  localparam int ERROR_COUNT_WIDTH = 16;

  // The timer is sized for the largest legal TIMEOUT_CYCLES so that one
  // type serves every instance; $clog2(65535+1) = 16 bits.
  localparam int TIMEOUT_CYCLES_MAX = 65535;
  localparam int TIMER_WIDTH        = $clog2(TIMEOUT_CYCLES_MAX + 1);

  typedef logic [TIMER_WIDTH-1:0]       timer_t;
  typedef logic [ERROR_COUNT_WIDTH-1:0] error_count_t;

  // Add up to three errors to the counter, sticking at all-ones.
  function automatic error_count_t error_count_add(error_count_t count, logic [1:0] inc);
    logic [ERROR_COUNT_WIDTH:0] sum;
    sum = {1'b0, count} + {{(ERROR_COUNT_WIDTH-1){1'b0}}, inc};
    return sum[ERROR_COUNT_WIDTH] ? '1 : sum[ERROR_COUNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/io_fabric_io_address_decoder.sv
// Window decoder: maps a byte address onto one of NUM_SLAVES equal windows.
module io_address_decoder #(
  parameter int unsigned              NUM_SLAVES   = 8,
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDRESS = '0,
  parameter int unsigned              SPAN_LOG2    = 4,
  parameter int unsigned              IDX_WIDTH    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] io_address,
  output logic                  hit,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic [SPAN_LOG2-1:0]  offset
);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_window;

  // Addresses below the base wrap to huge offsets, so the explicit
  // lower-bound compare is what rejects them.
  always_comb begin
    w_offset = io_address - BASE_ADDRESS;
    w_window = w_offset >> SPAN_LOG2;
    hit      = (io_address >= BASE_ADDRESS) && (w_window < ADDR_WIDTH'(NUM_SLAVES));
    idx      = w_window[IDX_WIDTH-1:0];
    offset   = w_offset[SPAN_LOG2-1:0];
  end

endmodule

// File: rtl/io_fabric.sv
// IO-bus fabric: decodes core IO commands onto NUM_SLAVES peripheral windows,
// waits for variable-latency read responses and tracks bus errors.
module io_fabric
  import io_fabric_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 8,
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDRESS   = '0,
  parameter int unsigned              SPAN_LOG2      = 4,
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]    ERROR_DATA     = DATA_WIDTH'(32'hdeadbeef)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             io_write_en,
  input  logic                             io_read_en,
  input  logic [ADDR_WIDTH-1:0]            io_address,
  input  logic [DATA_WIDTH-1:0]            io_write_data,
  output logic [DATA_WIDTH-1:0]            io_read_data,
  output logic                             io_read_valid,
  output logic                             io_busy,
  output logic [NUM_SLAVES-1:0]            s_write_en,
  output logic [NUM_SLAVES-1:0]            s_read_en,
  output logic [SPAN_LOG2-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]            s_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]            s_read_valid,
  input  logic                             error_clear,
  output logic [ERROR_COUNT_WIDTH-1:0]     error_count,
  output logic                             timeout_flag
);

  localparam int unsigned IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic                  w_hit;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic [SPAN_LOG2-1:0]  w_offset;

  io_address_decoder #(
    .NUM_SLAVES   (NUM_SLAVES),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BASE_ADDRESS (BASE_ADDRESS),
    .SPAN_LOG2    (SPAN_LOG2),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_decoder (
    .io_address (io_address),
    .hit        (w_hit),
    .idx        (w_idx),
    .offset     (w_offset)
  );

  io_fabric_state_t      r_state;
  io_fabric_state_t      w_state_next;
  logic [IDX_WIDTH-1:0]  r_target;
  timer_t                r_timer;
  logic [NUM_SLAVES-1:0] r_s_write_en;
  logic [NUM_SLAVES-1:0] r_s_read_en;
  logic [SPAN_LOG2-1:0]  r_s_address;
  logic [DATA_WIDTH-1:0] r_s_write_data;
  logic [DATA_WIDTH-1:0] r_io_read_data;
  logic                  r_io_read_valid;
  error_count_t          r_error_count;
  logic                  r_timeout_flag;

  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_target_valid;
  logic [DATA_WIDTH-1:0] w_target_data;
  logic                  w_strobe_cycle;
  logic                  w_timeout;
  logic                  w_cmd;

  logic [IDX_WIDTH-1:0]  w_target_next;
  timer_t                w_timer_next;
  logic [NUM_SLAVES-1:0] w_s_write_en_next;
  logic [NUM_SLAVES-1:0] w_s_read_en_next;
  logic [SPAN_LOG2-1:0]  w_s_address_next;
  logic [DATA_WIDTH-1:0] w_s_write_data_next;
  logic [DATA_WIDTH-1:0] w_io_read_data_next;
  logic                  w_io_read_valid_next;
  logic [1:0]            w_err_inc;
  logic                  w_timeout_set;

  // Strobe pattern for the decoded window and response selection for the latched target.
  always_comb begin
    w_onehot       = '0;
    w_target_valid = 1'b0;
    w_target_data  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      w_onehot[i] = (w_idx == IDX_WIDTH'(i));
      if (r_target == IDX_WIDTH'(i)) begin
        w_target_valid = s_read_valid[i];
        w_target_data  = s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The timer only starts counting once the read strobe has gone out, so a
  // TIMEOUT_CYCLES wait covers full cycles after the slave saw its strobe.
  assign w_strobe_cycle = |r_s_read_en;
  assign w_timeout      = (r_state == WAIT_RESP) && !w_strobe_cycle && !w_target_valid &&
                          (r_timer == timer_t'(TIMEOUT_CYCLES - 1));
  assign w_cmd          = io_write_en | io_read_en;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (io_read_en && !io_write_en) begin
          w_state_next = w_hit ? WAIT_RESP : MISS_RESP;
        end
      end
      WAIT_RESP: begin
        if (w_target_valid || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      MISS_RESP: w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Output logic: next values of every registered output plus error bookkeeping.
  always_comb begin
    w_target_next        = r_target;
    w_timer_next         = r_timer;
    w_s_write_en_next    = '0;
    w_s_read_en_next     = '0;
    w_s_address_next     = r_s_address;
    w_s_write_data_next  = r_s_write_data;
    w_io_read_data_next  = r_io_read_data;
    w_io_read_valid_next = 1'b0;
    w_err_inc            = 2'd0;
    w_timeout_set        = 1'b0;
    case (r_state)
      IDLE: begin
        w_s_address_next = w_offset;
        if (io_write_en) begin
          if (w_hit) begin
            w_s_write_en_next   = w_onehot;
            w_s_write_data_next = io_write_data;
          end else begin
            w_err_inc = w_err_inc + 2'd1;
          end
          // A read issued alongside a write is dropped and counted.
          if (io_read_en) begin
            w_err_inc = w_err_inc + 2'd1;
          end
        end else if (io_read_en && w_hit) begin
          w_s_read_en_next = w_onehot;
          w_target_next    = w_idx;
          w_timer_next     = '0;
        end
      end
      WAIT_RESP: begin
        if (w_cmd) begin
          w_err_inc = w_err_inc + 2'd1;
        end
        if (!w_strobe_cycle) begin
          w_timer_next = r_timer + timer_t'(1);
        end
        if (w_target_valid) begin
          w_io_read_data_next  = w_target_data;
          w_io_read_valid_next = 1'b1;
        end else if (w_timeout) begin
          w_io_read_data_next  = ERROR_DATA;
          w_io_read_valid_next = 1'b1;
          w_timeout_set        = 1'b1;
          w_err_inc            = w_err_inc + 2'd1;
        end
      end
      MISS_RESP: begin
        if (w_cmd) begin
          w_err_inc = w_err_inc + 2'd1;
        end
        w_io_read_data_next  = ERROR_DATA;
        w_io_read_valid_next = 1'b1;
        w_err_inc            = w_err_inc + 2'd1;
      end
      default: ;
    endcase
  end

  // Registered datapath, strobes and error tracking; clear beats any increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target        <= '0;
      r_timer         <= '0;
      r_s_write_en    <= '0;
      r_s_read_en     <= '0;
      r_s_address     <= '0;
      r_s_write_data  <= '0;
      r_io_read_data  <= '0;
      r_io_read_valid <= 1'b0;
      r_error_count   <= '0;
      r_timeout_flag  <= 1'b0;
    end else begin
      r_target        <= w_target_next;
      r_timer         <= w_timer_next;
      r_s_write_en    <= w_s_write_en_next;
      r_s_read_en     <= w_s_read_en_next;
      r_s_address     <= w_s_address_next;
      r_s_write_data  <= w_s_write_data_next;
      r_io_read_data  <= w_io_read_data_next;
      r_io_read_valid <= w_io_read_valid_next;
      if (error_clear) begin
        r_error_count  <= '0;
        r_timeout_flag <= 1'b0;
      end else begin
        r_error_count <= error_count_add(r_error_count, w_err_inc);
        if (w_timeout_set) begin
          r_timeout_flag <= 1'b1;
        end
      end
    end
  end

  assign io_busy       = (r_state != IDLE);
  assign io_read_data  = r_io_read_data;
  assign io_read_valid = r_io_read_valid;
  assign s_write_en    = r_s_write_en;
  assign s_read_en     = r_s_read_en;
  assign s_address     = r_s_address;
  assign s_write_data  = r_s_write_data;
  assign error_count   = r_error_count;
  assign timeout_flag  = r_timeout_flag;

endmodule
